sra_sequential_shifter: RTL
===========================

Name: sra_sequential_shifter

Overview:
- Multi-cycle right-shift unit: the right-direction counterpart to the ALU's left-shift stage chain.
- Performs logical or arithmetic right shift of a 32-bit operand by 0–31.
- Uses one binary stage per clock: 16, 8, 4, 2, 1.
- Sits beside the ALU as a low-area shifter for the CPU's multi-cycle path, with a start/ready handshake like the multdiv unit.

Parameters:
EARLY_EXIT, 0, 0 = fixed 5-cycle latency; 1 = finish as soon as all remaining lower shift-amount bits are zero.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
ctrl_start  input  1  request pulse; sampled on rising edge.
data_operandA  input  32  operand, captured on accepted start.
ctrl_shiftamt  input  5  shift amount, captured on accepted start.
ctrl_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured on accepted start.
data_result  output  32  shifted result; registered; valid while data_resultRDY=1.
data_resultRDY  output  1  result-valid flag.
busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - State → IDLE.
  - data_result=0, data_resultRDY=0, busy=0.
  - Working register, captured amount, arith flag and stage counter all cleared.
  - Reset mid-operation aborts the operation; no result is produced.
- States:
  - IDLE: no operation in flight, no valid result.
  - SHIFT: operation in progress.
  - DONE: result valid.
- Start acceptance:
  - ctrl_start=1 at an edge in IDLE or DONE (busy=0) is accepted at that edge (T0).
  - At T0: capture operand, amount and arith into working registers; stage counter k=4; busy=1; data_resultRDY=0; go to SHIFT.
  - data_result keeps its old value until completion.
- SHIFT, each edge:
  - If amt[k]=1, working register shifts right by 2^k.
  - Vacated MSBs are filled with the captured operand bit 31 if arith=1, else 0.
  - If amt[k]=0, working register is unchanged.
  - Then k decrements.
- Completion:
  - EARLY_EXIT=0: completion is at the edge that processes k=0 (T5). Latency is exactly 5 cycles from T0.
  - EARLY_EXIT=1: completion is at the edge processing stage k when amt[k-1:0]==0 (k=0 always completes). amt=0 completes at T1; latency is 1–5 cycles.
  - At the completion edge: data_result ← final shifted value; data_resultRDY=1; busy=0; go to DONE.
- DONE:
  - data_result and data_resultRDY hold until the next accepted start or reset.
  - A start in DONE is accepted at that edge; data_resultRDY falls at the same edge.
- ctrl_start while busy=1 is ignored. The in-flight operation and its captured inputs are unaffected.
- Input changes after T0 have no effect on the in-flight operation.
- Shift amounts are 0..31 only; no out-of-range case exists.
- amt=0 returns the operand unchanged for both modes.
- Arithmetic shift of a negative operand by 31 yields 0xFFFFFFFF.

Test Plan:
- Reset, then op=0x80000001, amt=0, arith=1, EARLY_EXIT=0 → data_result=0x80000001, data_resultRDY=1 exactly 5 edges after T0; busy high for T0..T4 edges.
- op=0x80000000, amt=31: arith=1 → 0xFFFFFFFF; arith=0 → 0x00000001.
- op=0xF0F0F0F0, amt=4: logical → 0x0F0F0F0F; arithmetic → 0xFF0F0F0F. Back-to-back start issued in DONE: RDY drops at that edge and the new result appears 5 edges later.
- Start op=0x00000100, amt=8; second start (op=0xFFFFFFFF, amt=1) while busy → ignored; result 0x00000001; one RDY assertion only.
- Start op=0xDEADBEEF, amt=3; assert reset low between T2 and T3 → outputs immediately 0, busy=0; after release, new op=0x00000010, amt=4 logical → 0x00000001.
- EARLY_EXIT=1: op=0x12345678, amt=16, logical → 0x00001234 with RDY after 1 edge. Same op with amt=1 → 0x091A2B3C after 5 edges.

Source files
------------

// File: rtl/sra_sequential_shifter.sv
// Multi-cycle right shifter: one binary stage (16, 8, 4, 2, 1) per clock with a
// start/ready handshake. Logical or arithmetic fill; optional early completion.
module sra_sequential_shifter #(
  parameter int EARLY_EXIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic [31:0] data_operandA,
  input  logic [4:0]  ctrl_shiftamt,
  input  logic        ctrl_arith,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_work;
  logic [4:0]  r_amt;
  logic        r_fill;
  logic [2:0]  r_k;
  logic [31:0] r_result;
  logic        r_rdy;

  logic        w_accept;
  logic [4:0]  w_low_mask;
  logic        w_rem_zero;
  logic        w_last;
  logic [31:0] w_stage;
  logic        w_busy;

  // Shift by 2^k, filling the vacated MSBs with the captured fill bit.
  function automatic logic [31:0] stage_shift(input logic [31:0] v,
                                              input logic [2:0]  k,
                                              input logic        fill);
    logic [31:0] fill_mask;
    fill_mask = ~(32'hFFFF_FFFF >> (5'd1 << k));
    stage_shift = (v >> (5'd1 << k)) | (fill ? fill_mask : 32'h0);
  endfunction

  assign w_accept   = ctrl_start && (r_state != S_SHIFT);
  assign w_low_mask = (5'd1 << r_k) - 5'd1;
  assign w_rem_zero = ((r_amt & w_low_mask) == 5'd0);
  assign w_last     = (r_k == 3'd0) || ((EARLY_EXIT != 0) && w_rem_zero);
  assign w_stage    = r_amt[r_k] ? stage_shift(r_work, r_k, r_fill) : r_work;

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_work   <= 32'h0;
      r_amt    <= 5'd0;
      r_fill   <= 1'b0;
      r_k      <= 3'd0;
      r_result <= 32'h0;
      r_rdy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_work <= data_operandA;
        r_amt  <= ctrl_shiftamt;
        r_fill <= ctrl_arith & data_operandA[31];
        r_k    <= 3'd4;
        r_rdy  <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        r_work <= w_stage;
        r_k    <= r_k - 3'd1;
        if (w_last) begin
          r_result <= w_stage;
          r_rdy    <= 1'b1;
        end
      end
    end
  end

  assign data_result    = r_result;
  assign data_resultRDY = r_rdy;
  assign busy           = w_busy;

endmodule
